// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants and enumerations for the multi-channel PWM generator.
//   CNT_W_DEF  : default width of counter, period and duty values
//   N_CH_MAX   : largest supported channel count
//   pwm_mode_e : edge-aligned or center-aligned counting
//   cnt_dir_e  : counter direction, doubles as the counter FSM state
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam int CNT_W_DEF = 28;
   localparam int N_CH_MAX  = 16;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } cnt_dir_e;

endpackage

// File: rtl/pwm_chan_cmp.sv
// ---------------------------------------------------------------------------
// pwm_chan_cmp
// One PWM channel: holds the channel's shadowed duty value, compares it with
// the shared period counter and drives a registered, polarity-adjusted output.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   load        copy duty_in into the duty shadow on this cycle
//   active      channel may drive its active level (running, period nonzero)
//   polarity    0 = active-high, 1 = active-low, applied live
//   duty_in     duty value to be shadowed
//   cnt         shared period counter
//   pwm_out     registered PWM output
// ---------------------------------------------------------------------------
module pwm_chan_cmp
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic             active,
   input  logic             polarity,
   input  logic [CNT_W-1:0] duty_in,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm_out
);

   logic [CNT_W-1:0] duty_q;
   logic             raw;

   // Duty shadow: only changes while idle or on the period boundary, so a
   // running period always finishes with the duty it started with.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         duty_q <= '0;
      end else if (load) begin
         duty_q <= duty_in;
      end
   end

   // Since cnt never reaches the period, any duty at or above the period
   // keeps raw high for the whole period without a notch at the boundary.
   assign raw = active & (cnt < duty_q);

   // Output flop: polarity is applied after the compare so an inactive
   // channel rests at its polarity level.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= raw ^ polarity;
      end
   end

endmodule

// File: rtl/pwm_multi_chan.sv
// ---------------------------------------------------------------------------
// pwm_multi_chan
// N-channel PWM generator with one shared period counter. Period, duty and
// alignment mode are double-buffered and only take effect at the period
// boundary (or while disabled), so outputs never glitch mid-period.
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   enable       1 = run, 0 = counter held at 0 and outputs inactive
//   center_mode  0 = edge-aligned, 1 = center-aligned (shadowed)
//   period_in    period in counts (shadowed)
//   duty_in      per-channel duty, channel i at [i*CNT_W +: CNT_W] (shadowed)
//   polarity     per-channel output polarity, 1 = active-low (live)
//   pwm_out      registered PWM outputs
//   period_end   registered one-cycle pulse following each period boundary
// ---------------------------------------------------------------------------
module pwm_multi_chan
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int N_CH  = 4
)
(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  enable,
   input  logic                  center_mode,
   input  logic [CNT_W-1:0]      period_in,
   input  logic [N_CH*CNT_W-1:0] duty_in,
   input  logic [N_CH-1:0]       polarity,
   output logic [N_CH-1:0]       pwm_out,
   output logic                  period_end
);

   cnt_dir_e         dir;
   cnt_dir_e         dir_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] per_q;
   logic [CNT_W-1:0] per_m1;
   pwm_mode_e        mode_q;
   logic             per_le1;
   logic             boundary;
   logic             load;
   logic             active;

   // per_m1 is only consulted when per_q >= 2, so its wrap at zero is harmless.
   assign per_m1  = per_q - CNT_W'(1);
   assign per_le1 = (per_q <= CNT_W'(1));
   assign load    = !enable || boundary;
   assign active  = enable && (per_q != '0);

   // Counter FSM state register: direction and count.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dir <= UP;
         cnt <= '0;
      end else begin
         dir <= dir_nxt;
         cnt <= cnt_nxt;
      end
   end

   // Next-state logic. Disable and every boundary restart at 0 counting up,
   // which also makes a mode change at the boundary start cleanly. In center
   // mode the turn-around cycle keeps cnt, so each endpoint is seen twice.
   always_comb begin
      dir_nxt = dir;
      cnt_nxt = cnt;
      if (!enable || boundary) begin
         dir_nxt = UP;
         cnt_nxt = '0;
      end else if (mode_q == PWM_EDGE) begin
         dir_nxt = UP;
         cnt_nxt = cnt + CNT_W'(1);
      end else begin
         case (dir)
            UP: begin
               if (cnt >= per_m1) begin
                  dir_nxt = DOWN;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            DOWN: begin
               cnt_nxt = cnt - CNT_W'(1);
            end
            default: begin
               dir_nxt = UP;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   // Output decode: the boundary is the last cycle of a period. A period of
   // 0 or 1 collapses to a single-cycle period in either mode.
   always_comb begin
      boundary = 1'b0;
      if (per_le1) begin
         boundary = 1'b1;
      end else if (mode_q == PWM_EDGE) begin
         boundary = (cnt >= per_m1);
      end else begin
         boundary = (dir == DOWN) && (cnt == '0);
      end
   end

   // Shared shadow registers and the period_end pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         per_q      <= '0;
         mode_q     <= PWM_EDGE;
         period_end <= 1'b0;
      end else begin
         if (load) begin
            per_q  <= period_in;
            mode_q <= pwm_mode_e'(center_mode);
         end
         period_end <= boundary & enable;
      end
   end

   // One compare channel per output.
   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      pwm_chan_cmp #(
         .CNT_W (CNT_W)
      ) u_chan (
         .CLK      (CLK),
         .RST_N    (RST_N),
         .load     (load),
         .active   (active),
         .polarity (polarity[i]),
         .duty_in  (duty_in[i*CNT_W +: CNT_W]),
         .cnt      (cnt),
         .pwm_out  (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_chan.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_chan
// Self-checking bench for pwm_multi_chan. A small 8-bit, 2-channel instance
// is driven cycle by cycle; a period-position model predicts every output,
// the prediction is queued when the inputs are driven and compared once the
// DUT has clocked. A 28-bit, 16-channel instance gets a duty-count smoke run.
// ---------------------------------------------------------------------------
module tb_pwm_multi_chan;

   localparam int W  = 8;
   localparam int NC = 2;

   logic            clk;
   logic            rst_n;
   logic            enable;
   logic            center_mode;
   logic [W-1:0]    period_in;
   logic [W-1:0]    duty_v [NC];
   logic [NC*W-1:0] duty_bus;
   logic [NC-1:0]   polarity;
   logic [NC-1:0]   pwm_out;
   logic            period_end;

   logic            en16;
   logic            cm16;
   logic [27:0]     per16;
   logic [16*28-1:0] duty16;
   logic [15:0]     pol16;
   logic [15:0]     pwm16;
   logic            pe16;

   int total_checks = 0;
   int bad_checks   = 0;
   string cur_tag   = "init";

   // model state: position within the period plus the shadowed settings
   int m_pos;
   int m_per;
   int m_duty [NC];
   bit m_mode;

   logic [2:0] sb_q [$];

   int hi0, hi1, pe_cnt;
   int hi16 [16];
   int pe16_cnt;

   assign duty_bus = {duty_v[1], duty_v[0]};

   pwm_multi_chan #(.CNT_W(W), .N_CH(NC)) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .enable      (enable),
      .center_mode (center_mode),
      .period_in   (period_in),
      .duty_in     (duty_bus),
      .polarity    (polarity),
      .pwm_out     (pwm_out),
      .period_end  (period_end)
   );

   pwm_multi_chan #(.CNT_W(28), .N_CH(16)) dut16 (
      .CLK         (clk),
      .RST_N       (rst_n),
      .enable      (en16),
      .center_mode (cm16),
      .period_in   (per16),
      .duty_in     (duty16),
      .polarity    (pol16),
      .pwm_out     (pwm16),
      .period_end  (pe16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_pos  = 0;
      m_per  = 0;
      m_mode = 1'b0;
      for (int i = 0; i < NC; i++) m_duty[i] = 0;
   endtask

   // Predict the outputs produced by the coming clock edge, then advance.
   task automatic modelStep(output logic [NC-1:0] e_pwm, output logic e_pe);
      int len;
      int c;
      bit bnd;
      bit act;
      if (m_per <= 1)  len = 1;
      else if (m_mode) len = 2 * m_per;
      else             len = m_per;
      if (m_per <= 1)                      c = 0;
      else if (m_mode && (m_pos >= m_per)) c = 2 * m_per - 1 - m_pos;
      else                                 c = m_pos;
      bnd = (m_pos == len - 1);
      for (int i = 0; i < NC; i++) begin
         act      = enable && (m_per != 0) && (c < m_duty[i]);
         e_pwm[i] = act ^ polarity[i];
      end
      e_pe = bnd && enable;
      if (!enable || bnd) begin
         m_pos  = 0;
         m_per  = int'(period_in);
         m_mode = center_mode;
         for (int i = 0; i < NC; i++) m_duty[i] = int'(duty_v[i]);
      end else begin
         m_pos++;
      end
   endtask

   // One clock: queue the prediction, clock the DUT, compare at the negedge.
   task automatic runCycle();
      logic [NC-1:0] e_pwm;
      logic          e_pe;
      logic [2:0]    exp_v;
      modelStep(e_pwm, e_pe);
      sb_q.push_back({e_pwm, e_pe});
      @(posedge clk);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checkOutput({cur_tag, ".pwm"}, 32'(pwm_out), 32'(exp_v[2:1]));
      checkOutput({cur_tag, ".pe"}, 32'(period_end), 32'(exp_v[0]));
      if (pwm_out[0] === 1'b1) hi0++;
      if (pwm_out[1] === 1'b1) hi1++;
      if (period_end === 1'b1) pe_cnt++;
      for (int i = 0; i < 16; i++) if (pwm16[i] === 1'b1) hi16[i]++;
      if (pe16 === 1'b1) pe16_cnt++;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) runCycle();
   endtask

   task automatic runWindow(input int n);
      hi0 = 0; hi1 = 0; pe_cnt = 0; pe16_cnt = 0;
      for (int i = 0; i < 16; i++) hi16[i] = 0;
      runCycles(n);
   endtask

   task automatic applyStimulus(input string tag, input logic en, input logic cm, input int per,
                                input int d0, input int d1, input logic [NC-1:0] pol);
      cur_tag     = tag;
      enable      = en;
      center_mode = cm;
      period_in   = W'(per);
      duty_v[0]   = W'(d0);
      duty_v[1]   = W'(d1);
      polarity    = pol;
   endtask

   task automatic runUntilPos(input int pos);
      for (int k = 0; k < 40 && m_pos != pos; k++) runCycle();
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus("reset", 1'b0, 1'b0, 0, 0, 0, 2'b00);
      en16 = 1'b0; cm16 = 1'b0; per16 = '0; pol16 = '0;
      for (int i = 0; i < 16; i++) duty16[i*28 +: 28] = 28'(i);
      modelReset();

      // reset state
      @(negedge clk);
      checkOutput("reset.pwm", 32'(pwm_out), 32'd0);
      checkOutput("reset.pe", 32'(period_end), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runCycles(2);

      // 1: edge mode, P=10, D0=3, D1=10
      applyStimulus("t1", 1'b1, 1'b0, 10, 3, 10, 2'b00);
      runCycles(25);
      runWindow(10);
      checkOutput("t1.hi0", hi0, 3);
      checkOutput("t1.hi1", hi1, 10);
      checkOutput("t1.pecnt", pe_cnt, 1);

      // 2: duty change mid-period only lands at the boundary
      cur_tag = "t2";
      runUntilPos(4);
      duty_v[0] = 8'd7;
      runCycles(25);
      runWindow(10);
      checkOutput("t2.hi0", hi0, 7);

      // 3: center mode, P=5, D0=2, then inverted polarity
      applyStimulus("t3", 1'b1, 1'b1, 5, 2, 0, 2'b00);
      runCycles(25);
      runWindow(10);
      checkOutput("t3.hi0", hi0, 4);
      checkOutput("t3.hi1", hi1, 0);
      checkOutput("t3.pecnt", pe_cnt, 1);
      applyStimulus("t3p", 1'b1, 1'b1, 5, 2, 0, 2'b01);
      runCycles(2);
      runWindow(10);
      checkOutput("t3p.hi0", hi0, 6);

      // 4: degenerate periods
      applyStimulus("t4p0", 1'b1, 1'b0, 0, 0, 255, 2'b00);
      runCycles(12);
      runWindow(4);
      checkOutput("t4p0.hi0", hi0, 0);
      checkOutput("t4p0.hi1", hi1, 0);
      checkOutput("t4p0.pecnt", pe_cnt, 4);
      applyStimulus("t4p1", 1'b1, 1'b0, 1, 1, 255, 2'b00);
      runCycles(3);
      runWindow(4);
      checkOutput("t4p1.hi0", hi0, 4);
      checkOutput("t4p1.hi1", hi1, 4);
      checkOutput("t4p1.pecnt", pe_cnt, 4);
      applyStimulus("t4p1c", 1'b1, 1'b1, 1, 0, 1, 2'b00);
      runCycles(6);

      // 5: drop enable mid-period, re-enable with new shadow values
      applyStimulus("t5", 1'b1, 1'b0, 10, 3, 5, 2'b10);
      runCycles(15);
      runUntilPos(6);
      applyStimulus("t5off", 1'b0, 1'b0, 8, 4, 5, 2'b10);
      runCycles(3);
      applyStimulus("t5on", 1'b1, 1'b0, 8, 4, 5, 2'b10);
      runCycles(16);
      runWindow(8);
      checkOutput("t5.hi0", hi0, 4);
      checkOutput("t5.hi1", hi1, 3);

      // 6: asynchronous reset between clock edges
      applyStimulus("t6", 1'b1, 1'b0, 10, 5, 10, 2'b00);
      runCycles(12);
      runUntilPos(2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6.async_pwm", 32'(pwm_out), 32'd0);
      checkOutput("t6.async_pe", 32'(period_end), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("t6.held_pwm", 32'(pwm_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      sb_q.delete();
      cur_tag = "t6rst";
      runCycles(25);
      runWindow(10);
      checkOutput("t6.hi0", hi0, 5);

      // 16-channel, 28-bit smoke run
      en16  = 1'b1;
      per16 = 28'd8;
      cur_tag = "smoke";
      runCycles(20);
      runWindow(8);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("smoke.ch%0d", i), hi16[i], (i < 8) ? i : 8);
      end
      checkOutput("smoke.pecnt", pe16_cnt, 1);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
